exec_stage: RTL

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 30 +++
 rtl/mul_iter.sv | 53 +++++
 rtl/exec_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states, flag layout
// and default widths.
package exec_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_AW_DEF = 3;

  // Bit positions inside flags = {C, N, Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MOV = 4'd7,
    OP_MUL = 4'd8
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low W bits kept.
// done/product are valid in the cycle of the final iteration.
module mul_iter #(
  parameter int unsigned W      = 16,
  parameter int unsigned CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [CW-1:0] cnt;
  logic          busy;

  assign acc_next = acc + (b_q[0] ? a_q : '0);
  assign done     = busy && (cnt == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc_next;
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
      cnt <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops write back one cycle after accept;
// MUL runs through mul_iter and stalls issue until its write-back.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] dest,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [2:0]        flags,
  output logic              illegal_op
);

  state_e              state;
  opcode_e             op;
  logic [REG_AW-1:0]   mul_dest;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                single_op;
  logic [DATA_W:0]     wide;
  logic [3:0]          sh;
  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [DATA_W-1:0]   mul_product;

  function automatic logic [2:0] mk_flags(input logic c, input logic [DATA_W-1:0] r);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = r[DATA_W-1];
    f[FLAG_Z] = (r == '0);
    return f;
  endfunction

  assign op          = opcode_e'(opcode);
  assign issue_ready = (state == ST_IDLE);
  assign accept      = issue_valid && issue_ready;
  assign mul_start   = accept && (op == OP_MUL);

  // One extra bit on the wide path carries carry/borrow/shifted-out bit
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    single_op = 1'b1;
    wide      = '0;
    sh        = op_b[3:0];
    case (op)
      OP_ADD: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_SUB: begin
        wide    = {1'b0, op_a} - {1'b0, op_b};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SHL: begin
        wide    = {1'b0, op_a} << sh;
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_SHR: begin
        wide    = {op_a, 1'b0} >> sh;
        alu_res = wide[DATA_W:1];
        alu_c   = wide[0];
      end
      OP_MOV:  alu_res = op_b;
      default: single_op = 1'b0;
    endcase
  end

  mul_iter #(
    .W      (DATA_W),
    .CYCLES (MUL_CYCLES)
  ) u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mul_dest   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      flags      <= '0;
      illegal_op <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (single_op) begin
              wr_en   <= 1'b1;
              wr_addr <= dest;
              wr_data <= alu_res;
              flags   <= mk_flags(alu_c, alu_res);
            end else if (op == OP_MUL) begin
              state    <= ST_MUL;
              mul_dest <= dest;
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state   <= ST_IDLE;
            wr_en   <= 1'b1;
            wr_addr <= mul_dest;
            wr_data <= mul_product;
            flags   <= mk_flags(1'b0, mul_product);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
